lfsr_galois_ctrl: RTL and testbench

Sequencer for the Galois LFSR core in the PRBS/scrambler datapath. Accepts one burst configuration through a valid/ready port: seed, polynomial, length, shift-per-step and word count. It validates the configuration, programs the core, then steps the core once per accepted output word. Words are delivered on a valid/ready stream with a last marker, so a consumer with backpressure never loses or repeats an LFSR state.

---
 rtl/lfsr_ctrl_pkg.sv | 33 +++
 rtl/lfsr_galois_ctrl.sv | 150 +++++++++++++++
 tb/tb_lfsr_galois_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and configuration check for the Galois LFSR sequencer.
// Configuration fields are zero-extended to MAX_W bits so one check serves any WIDTH up to 32.
package lfsr_ctrl_pkg;

   localparam int MAX_W     = 32;
   localparam int MAX_CNT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // The top tap must exist inside the register, and the shift must be 1..width steps.
   function automatic logic cfg_valid(
      input logic [MAX_W-1:0]     poly,
      input logic [MAX_W-1:0]     len,
      input logic [MAX_W-1:0]     shift,
      input logic [MAX_CNT_W-1:0] count,
      input int unsigned          width
   );
      logic len_ok;
      logic tap_ok;
      logic shift_ok;
      logic count_ok;
      len_ok   = (len < width);
      tap_ok   = poly[len[4:0]];
      shift_ok = (shift != '0) && (shift <= width);
      count_ok = (count != '0);
      return len_ok && tap_ok && shift_ok && count_ok;
   endfunction

endpackage

// File: rtl/lfsr_galois_ctrl.sv
// Burst sequencer for an external Galois LFSR core: validates a config, loads the core,
// then steps it once per accepted output word so backpressure never skips or repeats a state.
module lfsr_galois_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             CLK_I,
   input  logic             RST_N_I,
   input  logic             CFG_VALID_I,
   output logic             CFG_READY_O,
   input  logic [WIDTH-1:0] CFG_SEED_I,
   input  logic [WIDTH-1:0] CFG_POLY_I,
   input  logic [WIDTH-1:0] CFG_LEN_I,
   input  logic [WIDTH-1:0] CFG_SHIFT_I,
   input  logic [CNT_W-1:0] CFG_COUNT_I,
   input  logic             ABORT_I,
   output logic             LFSR_LOAD_O,
   output logic             LFSR_EN_O,
   output logic [WIDTH-1:0] LFSR_SEED_O,
   output logic [WIDTH-1:0] LFSR_POLY_O,
   output logic [WIDTH-1:0] LFSR_SHIFT_O,
   output logic [WIDTH-1:0] LFSR_LEN_O,
   input  logic [WIDTH-1:0] LFSR_DATA_I,
   output logic [WIDTH-1:0] DATA_O,
   output logic             DATA_VALID_O,
   input  logic             DATA_READY_I,
   output logic             DATA_LAST_O,
   output logic             BUSY_O,
   output logic             ERR_O
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] count_reg;
   logic [WIDTH-1:0] seed_reg, poly_reg, len_reg, shift_reg;
   logic             err_reg, err_next;
   logic             cfg_capture;

   logic [MAX_W-1:0]     poly_ext, len_ext, shift_ext;
   logic [MAX_CNT_W-1:0] count_ext;

   // Zero-extend the config fields to the width the shared check expects.
   for (genvar gi = 0; gi < MAX_W; gi++) begin : g_cfg_ext
      if (gi < WIDTH) begin : g_bit
         assign poly_ext[gi]  = CFG_POLY_I[gi];
         assign len_ext[gi]   = CFG_LEN_I[gi];
         assign shift_ext[gi] = CFG_SHIFT_I[gi];
      end else begin : g_zero
         assign poly_ext[gi]  = 1'b0;
         assign len_ext[gi]   = 1'b0;
         assign shift_ext[gi] = 1'b0;
      end
   end

   for (genvar gi = 0; gi < MAX_CNT_W; gi++) begin : g_cnt_ext
      if (gi < CNT_W) begin : g_bit
         assign count_ext[gi] = CFG_COUNT_I[gi];
      end else begin : g_zero
         assign count_ext[gi] = 1'b0;
      end
   end

   logic in_idle, in_load, in_run;
   logic cfg_fire, cfg_ok;
   logic data_fire, beat_last;

   assign in_idle   = (state_reg == ST_IDLE);
   assign in_load   = (state_reg == ST_LOAD);
   assign in_run    = (state_reg == ST_RUN);
   assign cfg_fire  = CFG_VALID_I && in_idle;
   assign cfg_ok    = cfg_valid(poly_ext, len_ext, shift_ext, count_ext, WIDTH);
   assign data_fire = in_run && DATA_READY_I;
   assign beat_last = (cnt_reg == (count_reg - CNT_W'(1)));

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      err_next    = err_reg;
      cfg_capture = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (cfg_fire) begin
               if (cfg_ok) begin
                  cfg_capture = 1'b1;
                  err_next    = 1'b0;
                  state_next  = ST_LOAD;
               end else begin
                  err_next    = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            cnt_next   = '0;
            state_next = ABORT_I ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            if (data_fire) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
            if (ABORT_I || (data_fire && beat_last)) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_N_I) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         count_reg <= '0;
         seed_reg  <= '0;
         poly_reg  <= '0;
         len_reg   <= '0;
         shift_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
         if (cfg_capture) begin
            seed_reg  <= CFG_SEED_I;
            poly_reg  <= CFG_POLY_I;
            len_reg   <= CFG_LEN_I;
            shift_reg <= CFG_SHIFT_I;
            count_reg <= CFG_COUNT_I;
         end
      end
   end

   assign CFG_READY_O  = in_idle;
   assign BUSY_O       = in_load || in_run;
   assign ERR_O        = err_reg;
   assign LFSR_LOAD_O  = in_load;
   // The last word and aborted words leave the core parked on the delivered state.
   assign LFSR_EN_O    = data_fire && !beat_last && !ABORT_I;
   assign LFSR_SEED_O  = seed_reg;
   assign LFSR_POLY_O  = poly_reg;
   assign LFSR_LEN_O   = len_reg;
   assign LFSR_SHIFT_O = shift_reg;
   assign DATA_VALID_O = in_run;
   assign DATA_LAST_O  = in_run && beat_last;
   assign DATA_O       = in_run ? LFSR_DATA_I : '0;

endmodule

// File: tb/tb_lfsr_galois_ctrl.sv
// Directed plus randomized bench for lfsr_galois_ctrl with a behavioural LFSR core and
// an expected-word model computed from the burst rules.
module tb_lfsr_galois_ctrl;

   logic        CLK_I = 1'b0;
   logic        RST_N_I = 1'b0;
   logic        CFG_VALID_I = 1'b0;
   logic        CFG_READY_O;
   logic [7:0]  CFG_SEED_I = '0;
   logic [7:0]  CFG_POLY_I = '0;
   logic [7:0]  CFG_LEN_I = '0;
   logic [7:0]  CFG_SHIFT_I = '0;
   logic [15:0] CFG_COUNT_I = '0;
   logic        ABORT_I = 1'b0;
   logic        LFSR_LOAD_O, LFSR_EN_O;
   logic [7:0]  LFSR_SEED_O, LFSR_POLY_O, LFSR_SHIFT_O, LFSR_LEN_O;
   logic [7:0]  LFSR_DATA_I;
   logic [7:0]  DATA_O;
   logic        DATA_VALID_O;
   logic        DATA_READY_I = 1'b0;
   logic        DATA_LAST_O, BUSY_O, ERR_O;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] cap_seed = '0, cap_poly = '0, cap_len = '0, cap_shift = '0;
   logic [7:0] core_q = '0;

   always #5 CLK_I = ~CLK_I;

   lfsr_galois_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
      .CLK_I(CLK_I), .RST_N_I(RST_N_I),
      .CFG_VALID_I(CFG_VALID_I), .CFG_READY_O(CFG_READY_O),
      .CFG_SEED_I(CFG_SEED_I), .CFG_POLY_I(CFG_POLY_I), .CFG_LEN_I(CFG_LEN_I),
      .CFG_SHIFT_I(CFG_SHIFT_I), .CFG_COUNT_I(CFG_COUNT_I), .ABORT_I(ABORT_I),
      .LFSR_LOAD_O(LFSR_LOAD_O), .LFSR_EN_O(LFSR_EN_O), .LFSR_SEED_O(LFSR_SEED_O),
      .LFSR_POLY_O(LFSR_POLY_O), .LFSR_SHIFT_O(LFSR_SHIFT_O), .LFSR_LEN_O(LFSR_LEN_O),
      .LFSR_DATA_I(LFSR_DATA_I), .DATA_O(DATA_O), .DATA_VALID_O(DATA_VALID_O),
      .DATA_READY_I(DATA_READY_I), .DATA_LAST_O(DATA_LAST_O), .BUSY_O(BUSY_O), .ERR_O(ERR_O)
   );

   // Galois right-shift step; taps limited to bits 0..len.
   function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input logic [7:0] poly,
                                           input logic [7:0] len, input logic [7:0] shift);
      logic [7:0] mask;
      logic [7:0] v;
      v    = s;
      mask = (len >= 8) ? 8'hFF : 8'((1 << (int'(len) + 1)) - 1);
      for (int i = 0; i < int'(shift); i++) begin
         if (v[0]) v = (v >> 1) ^ (poly & mask);
         else      v = v >> 1;
      end
      return v;
   endfunction

   function automatic bit ref_ok(input logic [7:0] poly, input logic [7:0] len,
                                 input logic [7:0] shift, input logic [15:0] count);
      if (len >= 8) return 1'b0;
      return poly[len[2:0]] && (shift >= 1) && (shift <= 8) && (count != 0);
   endfunction

   // Behavioural core: load on LOAD, advance SHIFT steps on EN.
   always @(posedge CLK_I) begin
      if (LFSR_LOAD_O)    core_q <= LFSR_SEED_O;
      else if (LFSR_EN_O) core_q <= lfsr_adv(core_q, LFSR_POLY_O, LFSR_LEN_O, LFSR_SHIFT_O);
   end
   assign LFSR_DATA_I = core_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_cfg(input logic [7:0] seed, input logic [7:0] poly, input logic [7:0] len,
                            input logic [7:0] shift, input logic [15:0] count);
      @(negedge CLK_I);
      CFG_VALID_I = 1'b1;
      CFG_SEED_I  = seed;
      CFG_POLY_I  = poly;
      CFG_LEN_I   = len;
      CFG_SHIFT_I = shift;
      CFG_COUNT_I = count;
      #1 check("cfg_ready_idle", CFG_READY_O, 1);
      @(negedge CLK_I);
      CFG_VALID_I = 1'b0;
      #1;
   endtask

   task automatic try_invalid(input logic [7:0] seed, input logic [7:0] poly, input logic [7:0] len,
                              input logic [7:0] shift, input logic [15:0] count);
      drive_cfg(seed, poly, len, shift, count);
      check("inv_err", ERR_O, 1);
      check("inv_no_load", LFSR_LOAD_O, 0);
      check("inv_busy", BUSY_O, 0);
      check("inv_ready", CFG_READY_O, 1);
      check("inv_seed_kept", LFSR_SEED_O, cap_seed);
      check("inv_poly_kept", LFSR_POLY_O, cap_poly);
      $display("[TB] reject seed=%h poly=%h len=%0d shift=%0d count=%0d err=%0b",
               seed, poly, len, shift, count, ERR_O);
   endtask

   // rmode: 0 always ready, 1 pattern 1,0,0, 2 random.
   task automatic run_burst(input logic [7:0] seed, input logic [7:0] poly, input logic [7:0] len,
                            input logic [7:0] shift, input logic [15:0] count,
                            input int rmode, input int abort_beat, input int rst_beat);
      logic [7:0] exp_q[$];
      logic [7:0] w;
      int  beat, cyc, en_seen;
      bit  done, rdy, ab, was_reset;
      w = seed;
      for (int k = 0; k < int'(count); k++) begin
         exp_q.push_back(w);
         w = lfsr_adv(w, poly, len, shift);
      end
      drive_cfg(seed, poly, len, shift, count);
      check("load_pulse", LFSR_LOAD_O, 1);
      check("load_busy", BUSY_O, 1);
      check("load_no_en", LFSR_EN_O, 0);
      check("load_no_valid", DATA_VALID_O, 0);
      check("load_err_clr", ERR_O, 0);
      check("seed_o", LFSR_SEED_O, seed);
      check("poly_o", LFSR_POLY_O, poly);
      check("len_o", LFSR_LEN_O, len);
      check("shift_o", LFSR_SHIFT_O, shift);
      cap_seed = seed; cap_poly = poly; cap_len = len; cap_shift = shift;
      beat = 0; cyc = 0; en_seen = 0; done = 0; was_reset = 0;
      while (!done && cyc < 2000) begin
         @(negedge CLK_I);
         if (beat == rst_beat) begin
            RST_N_I = 1'b0;
            DATA_READY_I = 1'b0;
            @(negedge CLK_I);
            RST_N_I = 1'b1;
            was_reset = 1;
            done = 1;
         end else begin
            case (rmode)
               0:       rdy = 1'b1;
               1:       rdy = (cyc % 3 == 0);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            ab = rdy && (beat == abort_beat);
            DATA_READY_I = rdy;
            ABORT_I = ab;
            #1;
            check("run_valid", DATA_VALID_O, 1);
            check("run_busy", BUSY_O, 1);
            check("run_data", DATA_O, exp_q[beat]);
            check("run_last", DATA_LAST_O, (beat == int'(count) - 1));
            check("run_en", LFSR_EN_O, rdy && !ab && (beat != int'(count) - 1));
            if (LFSR_EN_O) en_seen++;
            if (rdy) begin
               if (ab || beat == int'(count) - 1) done = 1;
               beat++;
            end
            cyc++;
         end
      end
      check("burst_done", done, 1);
      if (was_reset) begin
         #1;
         check("rst_ready", CFG_READY_O, 1);
         check("rst_err", ERR_O, 0);
         check("rst_busy", BUSY_O, 0);
         check("rst_valid", DATA_VALID_O, 0);
         check("rst_last", DATA_LAST_O, 0);
         check("rst_load", LFSR_LOAD_O, 0);
         check("rst_en", LFSR_EN_O, 0);
         check("rst_data", DATA_O, 0);
         check("rst_seed", LFSR_SEED_O, 0);
         check("rst_poly", LFSR_POLY_O, 0);
         check("rst_len", LFSR_LEN_O, 0);
         check("rst_shift", LFSR_SHIFT_O, 0);
         cap_seed = '0; cap_poly = '0; cap_len = '0; cap_shift = '0;
      end else begin
         @(negedge CLK_I);
         DATA_READY_I = 1'b0;
         ABORT_I = 1'b0;
         #1;
         check("end_valid", DATA_VALID_O, 0);
         check("end_ready", CFG_READY_O, 1);
         check("end_busy", BUSY_O, 0);
         check("end_en", LFSR_EN_O, 0);
         check("end_last", DATA_LAST_O, 0);
      end
      $display("[TB] burst seed=%h poly=%h len=%0d shift=%0d count=%0d mode=%0d beats=%0d steps=%0d reset=%0b",
               seed, poly, len, shift, count, rmode, beat, en_seen, was_reset);
   endtask

   initial begin
      logic [7:0]  r_seed, r_poly, r_len, r_shift;
      logic [15:0] r_count;

      RST_N_I = 1'b0;
      repeat (3) @(posedge CLK_I);
      @(negedge CLK_I);
      #1;
      check("por_ready", CFG_READY_O, 1);
      check("por_busy", BUSY_O, 0);
      check("por_err", ERR_O, 0);
      check("por_valid", DATA_VALID_O, 0);
      check("por_load", LFSR_LOAD_O, 0);
      check("por_seed", LFSR_SEED_O, 0);
      RST_N_I = 1'b1;

      run_burst(8'h01, 8'h1D, 8'd4, 8'd1, 16'd4, 0, -1, -1);
      run_burst(8'h01, 8'h1D, 8'd4, 8'd1, 16'd4, 1, -1, -1);

      try_invalid(8'h33, 8'h10, 8'd2, 8'd1, 16'd4);
      try_invalid(8'h33, 8'h1D, 8'd4, 8'd0, 16'd4);
      try_invalid(8'h33, 8'h1D, 8'd4, 8'd1, 16'd0);
      try_invalid(8'h33, 8'hFF, 8'd8, 8'd1, 16'd4);
      try_invalid(8'h33, 8'h1D, 8'd4, 8'd9, 16'd4);
      run_burst(8'hA5, 8'h8E, 8'd7, 8'd8, 16'd6, 2, -1, -1);

      run_burst(8'h5A, 8'h1D, 8'd4, 8'd3, 16'd1, 0, -1, -1);
      run_burst(8'h01, 8'h1D, 8'd4, 8'd1, 16'd10, 0, 2, -1);
      run_burst(8'h01, 8'h1D, 8'd4, 8'd2, 16'd10, 0, -1, 3);
      run_burst(8'h7E, 8'hB8, 8'd7, 8'd1, 16'd5, 0, -1, -1);

      for (int it = 0; it < 16; it++) begin
         r_seed  = 8'($urandom);
         r_poly  = 8'($urandom);
         r_len   = 8'($urandom_range(0, 9));
         r_shift = 8'($urandom_range(0, 9));
         r_count = 16'($urandom_range(0, 9));
         if (ref_ok(r_poly, r_len, r_shift, r_count))
            run_burst(r_seed, r_poly, r_len, r_shift, r_count, 2,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1, -1);
         else
            try_invalid(r_seed, r_poly, r_len, r_shift, r_count);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
